// File: rtl/clk_gen_pkg.sv
// Shared constants and sizing helper for the clock-generation front end.
package clk_gen_pkg;

    localparam int EVEN_DIV = 28;
    localparam int ODD_DIV  = 5;
    localparam int GC_INC   = 2;
    localparam int GC_DEC   = 5;
    localparam int CNT_W    = 4;
    localparam int GC_W     = 8;

    // Bits needed for a counter that runs 0..ratio-1 (at least one bit).
    function automatic int cnt_width(input int ratio);
        return (ratio <= 2) ? 1 : $clog2(ratio);
    endfunction

endpackage

// File: rtl/clock_gen_odd_div_50.sv
// Odd-ratio clock divider with 50% duty: posedge phase counter plus a
// negedge copy of the high phase that stretches it by half a period.
module odd_div_50 #(
    parameter int ODD_DIV = 5
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic clk_o
);

    localparam int             P_W    = clk_gen_pkg::cnt_width(ODD_DIV);
    localparam logic [P_W-1:0] P_LAST = P_W'(ODD_DIV - 1);
    localparam logic [P_W-1:0] HI_CNT = P_W'((ODD_DIV - 1) / 2);

    logic [P_W-1:0] p_q, p_d;
    logic           a_q, a_d;
    logic           b_q;

    always_comb begin
        p_d = (p_q == P_LAST) ? '0 : p_q + P_W'(1);
        a_d = (p_q < HI_CNT);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            p_q <= '0;
            a_q <= 1'b0;
        end else begin
            p_q <= p_d;
            a_q <= a_d;
        end
    end

    // Half-period delayed copy extends the high phase to ODD_DIV/2 periods.
    always_ff @(negedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            b_q <= 1'b0;
        end else begin
            b_q <= a_q;
        end
    end

    assign clk_o = a_q | b_q;

endmodule

// File: rtl/clock_gen.sv
// Clock-generation front end: binary /2../16 dividers, even /EVEN_DIV and
// odd /ODD_DIV 50% clocks, and a strobe-stepped "glitchy" counter.
module clock_gen
    import clk_gen_pkg::*;
(
    input  logic            clkIn,
    input  logic            rst,
    output logic            clk_div_2,
    output logic            clk_div_4,
    output logic            clk_div_8,
    output logic            clk_div_16,
    output logic            clk_div_28,
    output logic            clk_div_5,
    output logic [GC_W-1:0] glitchy_counter
);

    localparam int               C28_W    = cnt_width(EVEN_DIV / 2);
    localparam logic [C28_W-1:0] C28_LAST = C28_W'(EVEN_DIV / 2 - 1);
    localparam logic [GC_W-1:0]  GC_INC_V = GC_W'(GC_INC);
    localparam logic [GC_W-1:0]  GC_DEC_V = GC_W'(GC_DEC);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [C28_W-1:0] c28_q, c28_d;
    logic             d28_q, d28_d;
    logic [GC_W-1:0]  gc_q, gc_d;
    logic             strb;

    // Strobe looks at the pre-increment count, so it fires on every 4th edge.
    assign strb = (cnt_q[1:0] == 2'b11);

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        c28_d = c28_q + C28_W'(1);
        d28_d = d28_q;
        if (c28_q == C28_LAST) begin
            c28_d = '0;
            d28_d = ~d28_q;
        end
        gc_d = strb ? (gc_q - GC_DEC_V) : (gc_q + GC_INC_V);
    end

    always_ff @(posedge clkIn or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            c28_q <= '0;
            d28_q <= 1'b0;
            gc_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            c28_q <= c28_d;
            d28_q <= d28_d;
            gc_q  <= gc_d;
        end
    end

    odd_div_50 #(
        .ODD_DIV (ODD_DIV)
    ) u_div_odd (
        .clk_i  (clkIn),
        .rst_ni (rst),
        .clk_o  (clk_div_5)
    );

    assign clk_div_2       = cnt_q[0];
    assign clk_div_4       = cnt_q[1];
    assign clk_div_8       = cnt_q[2];
    assign clk_div_16      = cnt_q[3];
    assign clk_div_28      = d28_q;
    assign glitchy_counter = gc_q;

endmodule

// File: tb/tb_clock_gen.sv
// Self-checking bench for clock_gen: vector table, hand sequences, and a
// randomized run with async reset pulses against an edge-count reference model.
module tb_clock_gen;

    logic       clk;
    logic       rst;
    logic       clk_div_2, clk_div_4, clk_div_8, clk_div_16, clk_div_28, clk_div_5;
    logic [7:0] glitchy_counter;

    int tests = 0;
    int fails = 0;
    int n     = 0;   // posedges seen since the last reset release

    clock_gen dut (
        .clkIn           (clk),
        .rst             (rst),
        .clk_div_2       (clk_div_2),
        .clk_div_4       (clk_div_4),
        .clk_div_8       (clk_div_8),
        .clk_div_16      (clk_div_16),
        .clk_div_28      (clk_div_28),
        .clk_div_5       (clk_div_5),
        .glitchy_counter (glitchy_counter)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct packed {
        logic [7:0] edge_n;
        logic       d2, d4, d8, d16, d28, d5;
        logic [7:0] gc;
    } vec_t;

    // Expected outputs after posedge n (neg=0) or the following negedge (neg=1).
    // Time is counted in half-periods h; /5 output is high for h in [2,7) mod 10.
    function automatic logic [13:0] model(input int nn, input bit neg);
        int         h;
        int         c;
        logic       d28, d5;
        logic [7:0] gc;
        if (nn == 0) return 14'h0;
        c   = nn % 16;
        d28 = ((nn / 14) % 2) == 1;
        h   = 2 * nn + (neg ? 1 : 0);
        d5  = ((h - 2) % 10) < 5;
        gc  = 8'((2 * nn - 7 * (nn / 4)) % 256);
        return {c[0] != 0 ? 1'b1 : 1'b0, (c & 2) != 0, (c & 4) != 0, (c & 8) != 0,
                d28, d5, gc};
    endfunction

    task automatic check(input string name, input logic [13:0] exp);
        logic [13:0] act;
        act = {clk_div_2, clk_div_4, clk_div_8, clk_div_16, clk_div_28, clk_div_5,
               glitchy_counter};
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s (edge %0d): got d2/4/8/16=%b d28=%b d5=%b gc=%0d, want d2/4/8/16=%b d28=%b d5=%b gc=%0d",
                     name, n, act[13:10], act[9], act[8], act[7:0],
                     exp[13:10], exp[9], exp[8], exp[7:0]);
        end
    endtask

    vec_t tbl [12];

    initial begin
        tbl[0]  = '{8'd1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd2};
        tbl[1]  = '{8'd2,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd4};
        tbl[2]  = '{8'd3,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd6};
        tbl[3]  = '{8'd4,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1};
        tbl[4]  = '{8'd5,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd3};
        tbl[5]  = '{8'd6,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd5};
        tbl[6]  = '{8'd7,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd7};
        tbl[7]  = '{8'd8,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd2};
        tbl[8]  = '{8'd13, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd5};
        tbl[9]  = '{8'd14, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd7};
        tbl[10] = '{8'd27, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'd12};
        tbl[11] = '{8'd28, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd7};

        // Reset held low with the clock running: everything stays zero.
        rst = 1'b0;
        #5;
        repeat (5) begin
            check("reset_hold", 14'h0);
            #10;
        end
        @(negedge clk);
        #5 rst = 1'b1;
        n = 0;

        foreach (tbl[i]) begin
            while (n < int'(tbl[i].edge_n)) begin
                @(posedge clk);
                n++;
            end
            #1;
            check($sformatf("vec_edge%0d", tbl[i].edge_n),
                  {tbl[i].d2, tbl[i].d4, tbl[i].d8, tbl[i].d16, tbl[i].d28,
                   tbl[i].d5, tbl[i].gc});
        end

        // Half-period tail of /5: after edge 28's negedge only b has dropped.
        @(negedge clk);
        #1 check("div5_negedge28", {4'b0011, 1'b0, 1'b0, 8'd7});

        // Mid-run async reset between edges: clear is immediate, restart at edge 1.
        #4 rst = 1'b0;
        n = 0;
        #1 check("midrst_instant", 14'h0);
        @(posedge clk);
        #1 check("midrst_hold", 14'h0);
        @(negedge clk);
        #5 rst = 1'b1;
        @(posedge clk);
        n = 1;
        #1 check("midrst_restart", {4'b1000, 1'b0, 1'b1, 8'd2});
        @(negedge clk);
        #1 check("midrst_restart_neg", model(n, 1'b1));

        // Randomized run against the model, long enough to wrap the counter.
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk);
            n++;
            #1 check("rand_pos", model(n, 1'b0));
            @(negedge clk);
            #1 check("rand_neg", model(n, 1'b1));
            if (i == 1300 || (i > 1100 && $urandom_range(0, 49) == 0)) begin
                #($urandom_range(1, 7));
                rst = 1'b0;
                n   = 0;
                #1  check("rand_rst_instant", 14'h0);
                #10 check("rand_rst_hold", 14'h0);
                #9  rst = 1'b1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
